// File: rtl/data_cache_pkg.sv
// Shared types, geometry and address helpers for the direct-mapped data cache.
package data_cache_pkg;

  localparam int NUM_LINES      = 16;
  localparam int WORDS_PER_LINE = 4;
  localparam int ADDR_BITS      = 12;

  localparam int OFFSET_W = $clog2(WORDS_PER_LINE);
  localparam int INDEX_W  = $clog2(NUM_LINES);
  localparam int TAG_W    = ADDR_BITS - INDEX_W - OFFSET_W;
  localparam int PAD_W    = 32 - ADDR_BITS;

  localparam logic [OFFSET_W-1:0] LAST_WORD = OFFSET_W'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WRITE,
    DONE
  } state_t;

  typedef struct packed {
    logic [TAG_W-1:0]    tag;
    logic [INDEX_W-1:0]  index;
    logic [OFFSET_W-1:0] offset;
  } addr_fields_t;

  // Bits above ADDR_BITS are dropped here, so nothing downstream sees them.
  function automatic addr_fields_t split_addr(input logic [31:0] addr);
    addr_fields_t f;
    f = addr_fields_t'(addr[ADDR_BITS-1:0]);
    return f;
  endfunction

endpackage

// File: rtl/data_cache_if.sv
// Load/store port, Memory port and statistics outputs of the data cache.
interface data_cache_if;

  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    output cpu_rdata, cpu_ready, mem_read, mem_write, mem_addr, mem_wdata,
    output hit_count, miss_count
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    input  cpu_rdata, cpu_ready, mem_read, mem_write, mem_addr, mem_wdata,
    input  hit_count, miss_count
  );

endinterface

// File: rtl/data_cache_store.sv
// Valid/tag/data arrays: combinational lookup, one word-write port, one tag-set port.
module data_cache_store
  import data_cache_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [INDEX_W-1:0]  rd_index,
  input  logic [OFFSET_W-1:0] rd_offset,
  output logic                rd_valid,
  output logic [TAG_W-1:0]    rd_tag,
  output logic [31:0]         rd_word,
  input  logic                wr_en,
  input  logic [INDEX_W-1:0]  wr_index,
  input  logic [OFFSET_W-1:0] wr_offset,
  input  logic [31:0]         wr_data,
  input  logic                tag_we,
  input  logic [INDEX_W-1:0]  tag_index,
  input  logic [TAG_W-1:0]    tag_value
);

  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [31:0]          data_q [NUM_LINES*WORDS_PER_LINE];

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_word  = data_q[{rd_index, rd_offset}];

  // Reset only clears valid; tags and data are don't-care until revalidated.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (tag_we) begin
      valid_q[tag_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (tag_we) begin
      tag_q[tag_index] <= tag_value;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_q[{wr_index, wr_offset}] <= wr_data;
    end
  end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache.
// Optional load hit/miss counters are built when CACHE_STATS_EN is defined.
module data_cache
  import data_cache_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  data_cache_if.slave  bus
);

  state_t              state_q, state_d;
  addr_fields_t        lat_q, lat_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [OFFSET_W-1:0] cnt_q, cnt_d;

  addr_fields_t        req_f, look_f;
  logic                lk_valid, tag_hit;
  logic [TAG_W-1:0]    lk_tag;
  logic [31:0]         lk_word;
  logic                wr_en, tag_we;
  logic [OFFSET_W-1:0] wr_offset;
  logic [31:0]         wr_data;
  logic                load_hit, load_miss;

  assign req_f = split_addr(bus.cpu_addr);
  // IDLE decides hit/miss on the live request; WRITE checks the latched address.
  assign look_f  = (state_q == IDLE) ? req_f : lat_q;
  assign tag_hit = lk_valid && (lk_tag == look_f.tag);

  data_cache_store u_store (
    .clk       (clk),
    .rst       (rst),
    .rd_index  (look_f.index),
    .rd_offset (look_f.offset),
    .rd_valid  (lk_valid),
    .rd_tag    (lk_tag),
    .rd_word   (lk_word),
    .wr_en     (wr_en),
    .wr_index  (lat_q.index),
    .wr_offset (wr_offset),
    .wr_data   (wr_data),
    .tag_we    (tag_we),
    .tag_index (lat_q.index),
    .tag_value (lat_q.tag)
  );

  always_comb begin
    state_d   = state_q;
    lat_d     = lat_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    cnt_d     = cnt_q;
    wr_en     = 1'b0;
    wr_offset = lat_q.offset;
    wr_data   = wdata_q;
    tag_we    = 1'b0;
    load_hit  = 1'b0;
    load_miss = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.cpu_req) begin
          lat_d   = req_f;
          wdata_d = bus.cpu_wdata;
          cnt_d   = '0;
          if (bus.cpu_we) begin
            state_d = WRITE;
          end else if (tag_hit) begin
            rdata_d  = lk_word;
            load_hit = 1'b1;
            state_d  = DONE;
          end else begin
            load_miss = 1'b1;
            state_d   = FILL;
          end
        end
      end
      FILL: begin
        wr_en     = 1'b1;
        wr_offset = cnt_q;
        wr_data   = bus.mem_rdata;
        if (cnt_q == lat_q.offset) begin
          rdata_d = bus.mem_rdata;
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_WORD) begin
          tag_we  = 1'b1;
          state_d = DONE;
        end
      end
      WRITE: begin
        wr_en   = tag_hit;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lat_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    case (state_q)
      FILL:    bus.mem_addr = {{PAD_W{1'b0}}, lat_q.tag, lat_q.index, cnt_q};
      WRITE: begin
        bus.mem_addr  = {{PAD_W{1'b0}}, lat_q};
        bus.mem_wdata = wdata_q;
      end
      default: ;
    endcase
  end

  assign bus.mem_read  = (state_q == FILL);
  assign bus.mem_write = (state_q == WRITE);
  assign bus.cpu_ready = (state_q == DONE);
  assign bus.cpu_rdata = rdata_q;

`ifdef CACHE_STATS_EN
  logic [31:0] hit_q, hit_d, miss_q, miss_d;

  always_comb begin
    hit_d  = hit_q + {31'b0, load_hit};
    miss_d = miss_q + {31'b0, load_miss};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else begin
      hit_q  <= hit_d;
      miss_q <= miss_d;
    end
  end

  assign bus.hit_count  = hit_q;
  assign bus.miss_count = miss_q;
`else
  logic unused_stats;
  assign unused_stats   = load_hit ^ load_miss;
  assign bus.hit_count  = '0;
  assign bus.miss_count = '0;
`endif

endmodule
